// File: rtl/switch_debouncer.sv
// Per-channel push-button conditioner: 2-flop synchroniser, counter debounce,
// registered press/release edge pulses and a typematic auto-repeat pulse.
module switch_debouncer #(
   parameter int NUM_SWITCHES    = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 6250000,
   parameter int REPEAT_PERIOD   = 1250000
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   input  logic [NUM_SWITCHES-1:0] i_Switch,
   output logic [NUM_SWITCHES-1:0] o_Switch,
   output logic [NUM_SWITCHES-1:0] o_Press,
   output logic [NUM_SWITCHES-1:0] o_Release,
   output logic [NUM_SWITCHES-1:0] o_Repeat
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   localparam logic [DB_W-1:0] DB_TC  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DLY_TC = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [RP_W-1:0] PER_TC = RP_W'(REPEAT_PERIOD - 1);
   localparam bit              REP_EN = (REPEAT_DELAY > 0);

   localparam int N = NUM_SWITCHES;

   logic [N-1:0]            sync1_q, sync1_d;
   logic [N-1:0]            sync2_q, sync2_d;
   logic [N-1:0]            level_q, level_d;
   logic [N-1:0]            press_q, press_d;
   logic [N-1:0]            rel_q, rel_d;
   logic [N-1:0]            rpt_q, rpt_d;
   logic [N-1:0]            phase_q, phase_d;
   logic [N-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [N-1:0][RP_W-1:0]  rpt_cnt_q, rpt_cnt_d;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         rel_q     <= '0;
         rpt_q     <= '0;
         phase_q   <= '0;
         db_cnt_q  <= '0;
         rpt_cnt_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         rel_q     <= rel_d;
         rpt_q     <= rpt_d;
         phase_q   <= phase_d;
         db_cnt_q  <= db_cnt_d;
         rpt_cnt_q <= rpt_cnt_d;
      end
   end

   always_comb begin
      sync1_d   = i_Switch;
      sync2_d   = sync1_q;
      level_d   = level_q;
      press_d   = '0;
      rel_d     = '0;
      rpt_d     = '0;
      phase_d   = '0;
      db_cnt_d  = '0;
      rpt_cnt_d = '0;

      for (int i = 0; i < N; i++) begin
         // Counter only runs while the synchronised input disagrees with the accepted level.
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_TC) begin
               level_d[i] = sync2_q[i];
               press_d[i] = sync2_q[i];
               rel_d[i]   = ~sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end

         // A press restarts the repeat train; a release or idle level keeps it cleared.
         if (press_d[i]) begin
            rpt_d[i] = 1'b1;
         end else if (REP_EN && level_q[i] && !rel_d[i]) begin
            if (!phase_q[i] && rpt_cnt_q[i] == DLY_TC) begin
               rpt_d[i]   = 1'b1;
               phase_d[i] = 1'b1;
            end else if (phase_q[i] && rpt_cnt_q[i] == PER_TC) begin
               rpt_d[i]   = 1'b1;
               phase_d[i] = 1'b1;
            end else begin
               rpt_cnt_d[i] = rpt_cnt_q[i] + RP_W'(1);
               phase_d[i]   = phase_q[i];
            end
         end
      end
   end

   assign o_Switch  = level_q;
   assign o_Press   = press_q;
   assign o_Release = rel_q;
   assign o_Repeat  = rpt_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// compared every cycle against a sample-history/arithmetic reference model.
module tb_switch_debouncer;

   localparam int NS  = 4;
   localparam int D   = 4;
   localparam int RDA = 3;
   localparam int RPA = 2;
   localparam int RDB = 0;
   localparam int RPB = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NS-1:0] sw  = '0;

   logic [NS-1:0] sw_a, pr_a, rl_a, rp_a;
   logic [NS-1:0] sw_b, pr_b, rl_b, rp_b;

   always #5 clk = ~clk;

   switch_debouncer #(
      .NUM_SWITCHES(NS), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RDA), .REPEAT_PERIOD(RPA)
   ) u_dut_a (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw),
      .o_Switch(sw_a), .o_Press(pr_a), .o_Release(rl_a), .o_Repeat(rp_a)
   );

   switch_debouncer #(
      .NUM_SWITCHES(NS), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RDB), .REPEAT_PERIOD(RPB)
   ) u_dut_b (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw),
      .o_Switch(sw_b), .o_Press(pr_b), .o_Release(rl_b), .o_Repeat(rp_b)
   );

   int n_vec = 0;
   int n_err = 0;
   int t     = 0;

   // reference model state
   logic [NS-1:0] m_s1, m_s2, m_lvl;
   logic [D-1:0]  m_hist [NS];
   int            m_pt   [NS];
   logic [NS-1:0] e_pr, e_rl, e_rpa, e_rpb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, obs, exp_v);
      end
   endtask

   function automatic bit rep_due(input int rd, input int rp, input int d);
      if (rd == 0) return 1'b0;
      if (d == rd) return 1'b1;
      return (d > rd) && (((d - rd) % rp) == 0);
   endfunction

   task automatic model_reset();
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      e_pr  = '0;
      e_rl  = '0;
      e_rpa = '0;
      e_rpb = '0;
      for (int c = 0; c < NS; c++) begin
         m_hist[c] = '0;
         m_pt[c]   = 0;
      end
   endtask

   // A level is accepted once the last D synchronised samples all oppose it.
   task automatic model_edge(input logic [NS-1:0] sw_in);
      for (int c = 0; c < NS; c++) begin
         logic old;
         old       = m_lvl[c];
         m_hist[c] = {m_hist[c][D-2:0], m_s2[c]};
         e_pr[c]   = 1'b0;
         e_rl[c]   = 1'b0;
         e_rpa[c]  = 1'b0;
         e_rpb[c]  = 1'b0;
         if (m_hist[c] == {D{~old}}) begin
            m_lvl[c] = ~old;
            if (old) e_rl[c] = 1'b1;
            else     e_pr[c] = 1'b1;
         end
         if (e_pr[c]) begin
            m_pt[c]  = t;
            e_rpa[c] = 1'b1;
            e_rpb[c] = 1'b1;
         end else if (old && !e_rl[c]) begin
            e_rpa[c] = rep_due(RDA, RPA, t - m_pt[c]);
            e_rpb[c] = rep_due(RDB, RPB, t - m_pt[c]);
         end
      end
      m_s2 = m_s1;
      m_s1 = sw_in;
   endtask

   task automatic step();
      logic [NS-1:0] sw_pre;
      sw_pre = sw;
      @(posedge clk);
      t++;
      if (rst) model_reset();
      else     model_edge(sw_pre);
      #1;
      chk("sw_a",  32'(sw_a), 32'(m_lvl));
      chk("pr_a",  32'(pr_a), 32'(e_pr));
      chk("rl_a",  32'(rl_a), 32'(e_rl));
      chk("rp_a",  32'(rp_a), 32'(e_rpa));
      chk("sw_b",  32'(sw_b), 32'(m_lvl));
      chk("pr_b",  32'(pr_b), 32'(e_pr));
      chk("rl_b",  32'(rl_b), 32'(e_rl));
      chk("rp_b",  32'(rp_b), 32'(e_rpb));
   endtask

   task automatic wait_press(input int ch, input int exp_lat, input string tag);
      int t0;
      int k;
      t0 = t;
      k  = 0;
      do begin
         step();
         k++;
      end while (!pr_a[ch] && k < 30);
      chk(tag, 32'(t - t0), 32'(exp_lat));
   endtask

   task automatic wait_release(input int ch, input int exp_lat, input string tag);
      int t0;
      int k;
      t0 = t;
      k  = 0;
      do begin
         step();
         k++;
      end while (!rl_a[ch] && k < 30);
      chk(tag, 32'(t - t0), 32'(exp_lat));
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int k = 0; k < cycles; k++) step();
      rst = 1'b0;
   endtask

   initial begin
      int rate;
      int n_press_1;
      model_reset();
      #1;

      // reset with all switches held, then full-latency press on every channel
      sw = 4'b1111;
      do_reset(3);
      wait_press(0, D + 2, "rst_press_lat");
      chk("rst_press_all", 32'(pr_a), 32'hF);
      chk("rst_level_all", 32'(sw_a), 32'hF);
      sw = '0;
      for (int k = 0; k < 10; k++) step();

      // clean press on ch0
      do_reset(2);
      sw[0] = 1'b1;
      wait_press(0, D + 2, "clean_press_lat");
      step();
      chk("press_one_cycle", 32'(pr_a[0]), 32'h0);

      // bounce on ch1, exactly one press after final rise
      sw[1] = 1'b1; step(); step();
      sw[1] = 1'b0; step(); step();
      sw[1] = 1'b1; step(); step();
      sw[1] = 1'b0; step(); step();
      chk("bounce_quiet", 32'(sw_a[1]), 32'h0);
      sw[1] = 1'b1;
      n_press_1 = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (pr_a[1]) begin
            n_press_1++;
            chk("bounce_press_lat", 32'(k + 1), 32'(D + 2));
         end
      end
      chk("bounce_one_press", 32'(n_press_1), 32'h1);

      // ch3 held for repeat train, ch2 press then release
      sw[3] = 1'b1;
      sw[2] = 1'b1;
      for (int k = 0; k < 20; k++) step();
      sw[2] = 1'b0;
      wait_release(2, D + 2, "release_lat");
      for (int k = 0; k < 10; k++) step();
      sw = '0;
      for (int k = 0; k < 12; k++) step();

      // ch0 and ch3 pressed together, ch0 released mid-hold
      sw = 4'b1001;
      for (int k = 0; k < 15; k++) step();
      sw[0] = 1'b0;
      for (int k = 0; k < 15; k++) step();
      sw = '0;
      for (int k = 0; k < 10; k++) step();

      // random activity with varying toggle rates and occasional reset
      rate = 6;
      for (int k = 0; k < 3000; k++) begin
         if (k % 100 == 0) rate = $urandom_range(2, 24);
         for (int c = 0; c < NS; c++)
            if ($urandom_range(0, rate - 1) == 0) sw[c] = ~sw[c];
         if ($urandom_range(0, 599) == 0) do_reset(2);
         else step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
